// File: rtl/irq_ctrl_if.sv
// APB slave bus bundle for the interrupt controller.
// Signal names follow the controller's side of the bus (inputs _i, outputs _o).
interface irq_ctrl_if;
  logic        psel_i;
  logic        penable_i;
  logic        pwrite_i;
  logic [3:0]  paddr_i;
  logic [31:0] pwdata_i;
  logic [31:0] prdata_o;
  logic        pready_o;

  modport master (
    output psel_i, penable_i, pwrite_i, paddr_i, pwdata_i,
    input  prdata_o, pready_o
  );

  modport slave (
    input  psel_i, penable_i, pwrite_i, paddr_i, pwdata_i,
    output prdata_o, pready_o
  );
endinterface

// File: rtl/irq_ctrl.sv
// Interrupt controller: latches source requests into pending bits, masks them, picks the
// lowest-index active source and runs a claim/complete handshake with the core over APB.
module irq_ctrl #(
  parameter int N_SRC = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_SRC-1:0] irq_i,
  irq_ctrl_if.slave        apb,
  output logic             irq_o
);

  typedef enum logic [1:0] {IDLE, PEND, SERV} state_t;

  localparam logic [1:0] IDX_PENDING = 2'd0;
  localparam logic [1:0] IDX_ENABLE  = 2'd1;
  localparam logic [1:0] IDX_EDGE    = 2'd2;
  localparam logic [1:0] IDX_CLAIM   = 2'd3;

  state_t           r_state;
  logic [N_SRC-1:0] r_irq_d;
  logic [N_SRC-1:0] r_pending;
  logic [N_SRC-1:0] r_enable;
  logic [N_SRC-1:0] r_edge;
  logic [7:0]       r_claim_id;

  logic             w_access;
  logic             w_rd;
  logic             w_wr;
  logic [1:0]       w_idx;
  logic [N_SRC-1:0] w_set;
  logic [N_SRC-1:0] w_active;
  logic [N_SRC-1:0] w_w1c;
  logic [N_SRC-1:0] w_claim_clr;
  logic [N_SRC-1:0] w_win_oh;
  logic [7:0]       w_win_id;
  logic             w_any;
  logic             w_claim_rd;
  logic             w_claim_take;
  logic             w_complete_ok;
  logic             w_unused_ok;

  assign w_access = apb.psel_i & apb.penable_i;
  assign w_rd     = w_access & ~apb.pwrite_i;
  assign w_wr     = w_access &  apb.pwrite_i;
  assign w_idx    = apb.paddr_i[3:2];

  // Byte-lane bits and data bits above the implemented width are don't-care.
  assign w_unused_ok = ^{apb.paddr_i[1:0], apb.pwdata_i};

  assign w_set    = (r_edge & irq_i & ~r_irq_d) | (~r_edge & irq_i);
  assign w_active = r_pending & r_enable;
  assign w_any    = |w_active;

  // Fixed priority: scanning downwards lets the lowest active index win.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    w_win_oh = '0;
    w_win_id = 8'd0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (w_active[i]) begin
        w_win_oh    = '0;
        w_win_oh[i] = 1'b1;
        w_win_id    = 8'(i + 1);
      end
    end
  end

  assign w_claim_rd    = w_rd && (w_idx == IDX_CLAIM);
  assign w_claim_take  = w_claim_rd && (r_state == PEND) && w_any;
  assign w_complete_ok = w_wr && (w_idx == IDX_CLAIM) && (r_state == SERV) &&
                         (apb.pwdata_i[7:0] == r_claim_id);

  assign w_w1c       = (w_wr && (w_idx == IDX_PENDING)) ? apb.pwdata_i[N_SRC-1:0] : '0;
  assign w_claim_clr = w_claim_take ? w_win_oh : '0;

  always_comb begin
    apb.prdata_o = 32'd0;
    if (w_rd) begin
      unique case (w_idx)
        IDX_PENDING: apb.prdata_o = 32'(r_pending);
        IDX_ENABLE:  apb.prdata_o = 32'(r_enable);
        IDX_EDGE:    apb.prdata_o = 32'(r_edge);
        IDX_CLAIM:   apb.prdata_o = w_claim_take ? {24'd0, w_win_id} : 32'd0;
        default:     apb.prdata_o = 32'd0;
      endcase
    end
  end

  assign apb.pready_o = w_access;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_irq_d   <= '0;
      r_pending <= '0;
      r_enable  <= '0;
      r_edge    <= '0;
    end else begin
      r_irq_d   <= irq_i;
      // A new request in the same cycle as a clear keeps the bit pending.
      r_pending <= (r_pending & ~w_w1c & ~w_claim_clr) | w_set;
      if (w_wr && (w_idx == IDX_ENABLE)) r_enable <= apb.pwdata_i[N_SRC-1:0];
      if (w_wr && (w_idx == IDX_EDGE))   r_edge   <= apb.pwdata_i[N_SRC-1:0];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_claim_id <= 8'd0;
    end else begin
      unique case (r_state)
        IDLE: if (w_any) r_state <= PEND;
        PEND: begin
          if (w_claim_take) begin
            r_state    <= SERV;
            r_claim_id <= w_win_id;
          end else if (!w_any) begin
            r_state <= IDLE;
          end
        end
        SERV: begin
          if (w_complete_ok) begin
            r_state    <= IDLE;
            r_claim_id <= 8'd0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign irq_o = (r_state == PEND);

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: register reads are scored against a queue of expected values,
// interrupt line checks are inline in each scenario task.
module tb_irq_ctrl;

  localparam int N_SRC = 8;
  localparam logic [3:0] A_PENDING = 4'h0;
  localparam logic [3:0] A_ENABLE  = 4'h4;
  localparam logic [3:0] A_EDGE    = 4'h8;
  localparam logic [3:0] A_CLAIM   = 4'hC;

  logic             clk;
  logic             rst;
  logic [N_SRC-1:0] irq;
  logic             irq_out;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] sb_exp[$];
  string       sb_name[$];

  irq_ctrl_if bus ();

  irq_ctrl #(.N_SRC(N_SRC)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .irq_i (irq),
    .apb   (bus.slave),
    .irq_o (irq_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apb_write(input logic [3:0] addr, input logic [31:0] data);
    @(posedge clk); #1;
    bus.psel_i   = 1'b1;
    bus.pwrite_i = 1'b1;
    bus.paddr_i  = addr;
    bus.pwdata_i = data;
    @(posedge clk); #1;
    bus.penable_i = 1'b1;
    @(posedge clk); #1;
    bus.psel_i    = 1'b0;
    bus.penable_i = 1'b0;
    bus.pwrite_i  = 1'b0;
  endtask

  // Expected value is queued when the read is issued and compared when the DUT drives prdata.
  task automatic apb_read(input logic [3:0] addr, input logic [31:0] exp, input string name);
    logic [31:0] e;
    string       nm;
    sb_exp.push_back(exp);
    sb_name.push_back(name);
    @(posedge clk); #1;
    bus.psel_i   = 1'b1;
    bus.pwrite_i = 1'b0;
    bus.paddr_i  = addr;
    @(posedge clk); #1;
    bus.penable_i = 1'b1;
    #2;
    e  = sb_exp.pop_front();
    nm = sb_name.pop_front();
    n_checks++;
    if (bus.prdata_o !== e)
      $display("FAIL %s: prdata got 0x%08h expected 0x%08h", nm, bus.prdata_o, e);
    else n_pass++;
    n_checks++;
    if (bus.pready_o !== 1'b1)
      $display("FAIL %s_pready: got %b expected 1", nm, bus.pready_o);
    else n_pass++;
    @(posedge clk); #1;
    bus.psel_i    = 1'b0;
    bus.penable_i = 1'b0;
  endtask

  task automatic pulse(input int b);
    @(posedge clk); #1;
    irq[b] = 1'b1;
    @(posedge clk); #1;
    irq[b] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    n_checks++;
    if (irq_out !== 1'b0 || bus.prdata_o !== 32'd0 || bus.pready_o !== 1'b0)
      $display("FAIL reset_outputs: irq=%b prdata=0x%08h pready=%b expected 0/0/0",
               irq_out, bus.prdata_o, bus.pready_o);
    else n_pass++;
    step(2);
    rst = 1'b0;
    apb_write(A_ENABLE, 32'h1);
    apb_write(A_EDGE, 32'h80);
    pulse(0);
    step(1);
    apb_read(A_CLAIM, 32'd1, "reset_setup_claim");
    pulse(1);
    step(1);
    #3;
    rst = 1'b1;
    #1;
    n_checks++;
    if (irq_out !== 1'b0) $display("FAIL reset_async_irq: got %b expected 0", irq_out);
    else n_pass++;
    step(2);
    rst = 1'b0;
    apb_read(A_PENDING, 32'd0, "reset_pending");
    apb_read(A_ENABLE,  32'd0, "reset_enable");
    apb_read(A_EDGE,    32'd0, "reset_edge");
    apb_read(A_CLAIM,   32'd0, "reset_claim");
    n_checks++;
    if (irq_out !== 1'b0) $display("FAIL reset_irq_after: got %b expected 0", irq_out);
    else n_pass++;
  endtask

  task automatic test_level();
    apb_write(A_ENABLE, 32'h1);
    pulse(0);
    n_checks++;
    if (irq_out !== 1'b0) $display("FAIL level_irq_early: got %b expected 0", irq_out);
    else n_pass++;
    step(1);
    n_checks++;
    if (irq_out !== 1'b1) $display("FAIL level_irq_raise: got %b expected 1", irq_out);
    else n_pass++;
    apb_read(A_PENDING, 32'h1, "level_pending");
    apb_read(A_CLAIM,   32'd1, "level_claim");
    n_checks++;
    if (irq_out !== 1'b0) $display("FAIL level_irq_claimed: got %b expected 0", irq_out);
    else n_pass++;
    apb_write(A_CLAIM, 32'd1);
    step(2);
    n_checks++;
    if (irq_out !== 1'b0) $display("FAIL level_irq_done: got %b expected 0", irq_out);
    else n_pass++;
    apb_read(A_PENDING, 32'h0, "level_pending_done");
    apb_read(A_CLAIM,   32'd0, "level_claim_idle");
  endtask

  task automatic test_priority();
    apb_write(A_ENABLE, 32'h3);
    @(posedge clk); #1;
    irq[1:0] = 2'b11;
    @(posedge clk); #1;
    irq[1:0] = 2'b00;
    step(1);
    n_checks++;
    if (irq_out !== 1'b1) $display("FAIL prio_irq_raise: got %b expected 1", irq_out);
    else n_pass++;
    apb_read(A_CLAIM, 32'd1, "prio_claim_first");
    apb_write(A_CLAIM, 32'd1);
    step(1);
    n_checks++;
    if (irq_out !== 1'b1) $display("FAIL prio_irq_reassert: got %b expected 1", irq_out);
    else n_pass++;
    apb_read(A_CLAIM, 32'd2, "prio_claim_second");
    apb_write(A_CLAIM, 32'd2);
    step(2);
    n_checks++;
    if (irq_out !== 1'b0) $display("FAIL prio_irq_done: got %b expected 0", irq_out);
    else n_pass++;
    apb_read(A_PENDING, 32'h0, "prio_pending_done");
  endtask

  task automatic test_edge_mode();
    apb_write(A_EDGE, 32'h1);
    apb_write(A_ENABLE, 32'h1);
    @(posedge clk); #1;
    irq[0] = 1'b1;
    step(3);
    apb_read(A_CLAIM,   32'd1, "edge_claim");
    apb_read(A_PENDING, 32'h0, "edge_no_repend");
    apb_write(A_CLAIM, 32'd1);
    step(1);
    apb_read(A_PENDING, 32'h0, "edge_pending_after");
    n_checks++;
    if (irq_out !== 1'b0) $display("FAIL edge_irq_once: got %b expected 0", irq_out);
    else n_pass++;
    irq[0] = 1'b0;
    apb_write(A_EDGE, 32'h0);
    @(posedge clk); #1;
    irq[0] = 1'b1;
    step(3);
    apb_read(A_CLAIM,   32'd1, "lvl_claim");
    apb_read(A_PENDING, 32'h1, "lvl_repend");
    irq[0] = 1'b0;
    apb_write(A_CLAIM, 32'd1);
    step(1);
    n_checks++;
    if (irq_out !== 1'b1) $display("FAIL lvl_irq_reraise: got %b expected 1", irq_out);
    else n_pass++;
    apb_write(A_PENDING, 32'h1);
    step(2);
    n_checks++;
    if (irq_out !== 1'b0) $display("FAIL lvl_irq_w1c: got %b expected 0", irq_out);
    else n_pass++;
    apb_read(A_PENDING, 32'h0, "lvl_pending_cleared");
  endtask

  task automatic test_mask_w1c();
    apb_write(A_ENABLE, 32'h0);
    pulse(1);
    step(2);
    n_checks++;
    if (irq_out !== 1'b0) $display("FAIL mask_irq_masked: got %b expected 0", irq_out);
    else n_pass++;
    apb_read(A_PENDING, 32'h2, "mask_pending");
    apb_write(A_PENDING, 32'h2);
    apb_read(A_PENDING, 32'h0, "mask_w1c");
    apb_write(A_ENABLE, 32'h2);
    step(2);
    n_checks++;
    if (irq_out !== 1'b0) $display("FAIL mask_irq_after_enable: got %b expected 0", irq_out);
    else n_pass++;
    apb_read(A_ENABLE, 32'h2, "mask_enable_rb");
  endtask

  task automatic test_bad_complete();
    apb_write(A_ENABLE, 32'h1);
    pulse(0);
    step(1);
    apb_read(A_CLAIM, 32'd1, "nest_claim");
    pulse(0);
    step(1);
    n_checks++;
    if (irq_out !== 1'b0) $display("FAIL nest_irq_serv: got %b expected 0", irq_out);
    else n_pass++;
    apb_write(A_CLAIM, 32'd2);
    step(1);
    n_checks++;
    if (irq_out !== 1'b0) $display("FAIL nest_irq_bad_complete: got %b expected 0", irq_out);
    else n_pass++;
    apb_read(A_CLAIM,   32'd0, "nest_claim_in_serv");
    apb_read(A_PENDING, 32'h1, "nest_pending_kept");
    apb_write(A_CLAIM, 32'd1);
    step(1);
    n_checks++;
    if (irq_out !== 1'b1) $display("FAIL nest_irq_after_complete: got %b expected 1", irq_out);
    else n_pass++;
    apb_read(A_CLAIM, 32'd1, "nest_claim_again");
    apb_write(A_CLAIM, 32'd1);
    step(2);
    n_checks++;
    if (irq_out !== 1'b0) $display("FAIL nest_irq_final: got %b expected 0", irq_out);
    else n_pass++;
  endtask

  initial begin
    irq           = '0;
    bus.psel_i    = 1'b0;
    bus.penable_i = 1'b0;
    bus.pwrite_i  = 1'b0;
    bus.paddr_i   = 4'h0;
    bus.pwdata_i  = 32'h0;
    test_reset();
    test_level();
    test_priority();
    test_edge_mode();
    test_mask_w1c();
    test_bad_complete();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
